// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - FSM state encoding shared by the UART TX arbiter files
package uart_tx_arbiter_pkg;

   // Encodings line up with the uart_rx/uart_tx state machines
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_WAIT  = 2'b10
   } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational one-hot round-robin picker
module rr_pick #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   // Scan i_ptr, i_ptr+1, ... (mod N) and take the first requester found
   always_comb begin
      logic [IW-1:0] w_c;
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_c      = '0;
      for (int k = 0; k < N; k++) begin
         w_c = IW'((int'(i_ptr) + k) % N);
         if (!o_valid && i_req[w_c]) begin
            o_valid       = 1'b1;
            o_idx         = w_c;
            o_onehot[w_c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter sharing one uart_tx between requesters
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DBIT      = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      i_req,
   input  logic [NREQ*DBIT-1:0] i_req_data,
   input  logic [NREQ-1:0]      i_req_last,
   output logic [NREQ-1:0]      o_req_ack,
   output logic [NREQ-1:0]      o_grant,
   output logic                 o_tx_start,
   output logic [DBIT-1:0]      o_tx_din,
   input  logic                 i_tx_done_tick,
   output logic                 o_busy
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NREQ - 1);

   state_t          r_state, w_state_nxt;
   logic [NREQ-1:0] r_grant, w_grant_nxt;
   logic [NREQ-1:0] r_req_ack, w_req_ack_nxt;
   logic [IW-1:0]   r_gidx, w_gidx_nxt;
   logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
   logic [DBIT-1:0] r_tx_din, w_tx_din_nxt;
   logic [BW-1:0]   r_burst_cnt, w_burst_cnt_nxt;
   logic            r_lock_last, w_lock_last_nxt;
   logic            r_tx_start, w_tx_start_nxt;
   logic            r_busy, w_busy_nxt;

   logic [NREQ-1:0] w_pick_onehot;
   logic [IW-1:0]   w_pick_idx;
   logic            w_pick_valid;
   logic [DBIT-1:0] w_data_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_data_arr[gi] = i_req_data[gi*DBIT +: DBIT];
   end

   rr_pick #(.N(NREQ)) u_pick (
      .i_req    (i_req),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

   // Next-state logic: grant, burst continuation or release; strobes derive from the next state
   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_gidx_nxt      = r_gidx;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_tx_din_nxt    = r_tx_din;
      w_lock_last_nxt = r_lock_last;
      w_burst_cnt_nxt = r_burst_cnt;
      unique case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt     = ST_START;
               w_grant_nxt     = w_pick_onehot;
               w_gidx_nxt      = w_pick_idx;
               w_tx_din_nxt    = w_data_arr[w_pick_idx];
               w_lock_last_nxt = i_req_last[w_pick_idx];
               w_burst_cnt_nxt = '0;
            end
         end
         ST_START: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_tx_done_tick) begin
               if (r_lock_last || (r_burst_cnt == BURST_LAST) || !i_req[r_gidx]) begin
                  w_state_nxt  = ST_IDLE;
                  w_grant_nxt  = '0;
                  w_rr_ptr_nxt = (r_gidx == IDX_LAST) ? '0 : r_gidx + 1'b1;
               end else begin
                  w_state_nxt     = ST_START;
                  w_tx_din_nxt    = w_data_arr[r_gidx];
                  w_lock_last_nxt = i_req_last[r_gidx];
                  w_burst_cnt_nxt = r_burst_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
      w_tx_start_nxt = (w_state_nxt == ST_START);
      w_req_ack_nxt  = (w_state_nxt == ST_START) ? w_grant_nxt : '0;
      w_busy_nxt     = (w_state_nxt != ST_IDLE);
   end

   // State and output registers; reset clears everything immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_req_ack   <= '0;
         r_gidx      <= '0;
         r_rr_ptr    <= '0;
         r_tx_din    <= '0;
         r_burst_cnt <= '0;
         r_lock_last <= 1'b0;
         r_tx_start  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_req_ack   <= w_req_ack_nxt;
         r_gidx      <= w_gidx_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_tx_din    <= w_tx_din_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_lock_last <= w_lock_last_nxt;
         r_tx_start  <= w_tx_start_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign o_req_ack  = r_req_ack;
   assign o_grant    = r_grant;
   assign o_tx_start = r_tx_start;
   assign o_tx_din   = r_tx_din;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_tx
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int MB = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  i_req = '0;
   logic [N*DB-1:0] i_req_data = '0;
   logic [N-1:0]  i_req_last = '0;
   logic [N-1:0]  o_req_ack;
   logic [N-1:0]  o_grant;
   logic          o_tx_start;
   logic [DB-1:0] o_tx_din;
   logic          i_tx_done_tick = 1'b0;
   logic          o_busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(N), .DBIT(DB), .MAX_BURST(MB)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req          (i_req),
      .i_req_data     (i_req_data),
      .i_req_last     (i_req_last),
      .o_req_ack      (o_req_ack),
      .o_grant        (o_grant),
      .o_tx_start     (o_tx_start),
      .o_tx_din       (o_tx_din),
      .i_tx_done_tick (i_tx_done_tick),
      .o_busy         (o_busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0]  cq    [N][$];   // bytes still to be presented by each client {last,data}
   logic [8:0]  exp_q [N][$];   // bytes each client expects to see transmitted, in order
   logic [N-1:0] en = '1;
   logic [11:0] log_q [$];      // observed {client,byte} per tx_start
   logic [11:0] elog  [$];
   int          log_rd = 0;
   int          inj_req = 0;
   int          inj_ack = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      oh = '0;
      if (i >= 0 && i < N) oh[i] = 1'b1;
   endfunction

   task automatic push_byte(input int c, input logic [7:0] d, input logic l);
      cq[c].push_back({l, d});
      exp_q[c].push_back({l, d});
   endtask

   task automatic chk_log(input string nm);
      chk({nm, "_count"}, 32'(log_q.size() - log_rd), 32'(elog.size()));
      for (int i = 0; i < elog.size(); i++)
         if (log_rd + i < log_q.size()) chk(nm, 32'(log_q[log_rd + i]), 32'(elog[i]));
      log_rd = log_q.size();
      elog.delete();
   endtask

   function automatic bit quiet();
      quiet = !o_busy && !o_tx_start;
      for (int i = 0; i < N; i++) if (en[i] && cq[i].size() != 0) quiet = 1'b0;
   endfunction

   task automatic wait_quiet(input int maxc);
      int q = 0;
      int t = 0;
      while (q < 3 && t < maxc) begin
         @(negedge clk);
         t++;
         if (quiet()) q++; else q = 0;
      end
      chk("wait_quiet_timeout", 32'(q >= 3), 32'd1);
   endtask

   task automatic wait_start(input int c, input int maxc);
      int t = 0;
      bit seen = 1'b0;
      while (!seen && t < maxc) begin
         @(negedge clk);
         t++;
         if (o_tx_start && o_grant[c]) seen = 1'b1;
      end
      chk("wait_start_timeout", 32'(seen), 32'd1);
   endtask

   // Requester and uart_tx models: present queue heads, consume on ack, time frames
   int u_cnt = 0;
   bit u_busy = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         u_busy = 1'b0;
         i_tx_done_tick = 1'b0;
      end else begin
         for (int i = 0; i < N; i++)
            if (o_req_ack[i] && cq[i].size() > 0) void'(cq[i].pop_front());
         if (i_tx_done_tick) i_tx_done_tick = 1'b0;
         if (o_tx_start) begin
            u_busy = 1'b1;
            u_cnt  = $urandom_range(2, 10);
         end else if (u_busy) begin
            u_cnt--;
            if (u_cnt == 0) begin
               u_busy = 1'b0;
               i_tx_done_tick = 1'b1;
            end
         end else if (inj_req != inj_ack) begin
            inj_ack = inj_req;
            i_tx_done_tick = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         i_req[i] = en[i] && (cq[i].size() > 0);
         if (cq[i].size() > 0) begin
            i_req_data[i*DB +: DB] = cq[i][0][7:0];
            i_req_last[i]          = cq[i][0][8];
         end
      end
   end

   // Input snapshot at the active edge (inputs only change at the falling edge)
   logic [N-1:0] s_req = '0;
   logic s_done = 1'b0;
   logic s_rst = 1'b0;
   always @(posedge clk) begin
      s_req  = i_req;
      s_done = i_tx_done_tick;
      s_rst  = reset;
   end

   // Reference arbiter and scoreboard monitor
   int owner = -1;
   int ref_ptr = 0;
   int burst = 0;
   bit inflight = 1'b0;
   bit cur_last = 1'b0;
   logic [7:0] cur_byte = '0;
   always @(negedge clk) begin
      int e;
      logic [8:0] item;
      if (!reset) begin
         chk("reset_outputs", 32'({o_req_ack, o_grant, o_tx_start, o_tx_din, o_busy}), 32'd0);
         owner = -1; ref_ptr = 0; burst = 0; inflight = 1'b0;
      end else begin
         if (inflight && s_done && s_rst) begin
            inflight = 1'b0;
            if (cur_last || burst == MB || !s_req[owner]) begin
               chk("release", 32'({o_grant, o_tx_start, o_busy}), 32'd0);
               ref_ptr = (owner + 1) % N;
               owner = -1;
            end else begin
               chk("burst_next", 32'({o_grant, o_tx_start}), 32'({oh(owner), 1'b1}));
            end
         end else if (owner < 0) begin
            e = int'(s_rst && (s_req != '0));
            chk("idle_start", 32'({o_tx_start, o_busy}), 32'({e[0], e[0]}));
         end else begin
            chk("hold", 32'({o_grant, o_tx_din, o_tx_start, o_busy}), 32'({oh(owner), cur_byte, 1'b0, 1'b1}));
         end
         if (o_tx_start) begin
            if (owner < 0) begin
               e = -1;
               for (int k = 0; k < N; k++)
                  if (e < 0 && s_req[(ref_ptr + k) % N]) e = (ref_ptr + k) % N;
               owner = e;
               burst = 0;
            end
            burst++;
            cur_byte = o_tx_din;
            cur_last = 1'b0;
            inflight = 1'b1;
            if (owner < 0) begin
               n_cmp++; n_err++;
               $display("FAIL start_without_request: got grant %0h expected no start at %0t", o_grant, $time);
            end else begin
               chk("grant", 32'(o_grant), 32'(oh(owner)));
               chk("req_ack", 32'(o_req_ack), 32'(oh(owner)));
               if (exp_q[owner].size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL extra_byte: got %0h from client %0d expected none at %0t", o_tx_din, owner, $time);
               end else begin
                  item = exp_q[owner].pop_front();
                  chk("tx_byte", 32'(o_tx_din), 32'(item[7:0]));
                  cur_byte = item[7:0];
                  cur_last = item[8];
               end
               log_q.push_back({4'(owner), o_tx_din});
            end
         end else begin
            chk("no_ack", 32'(o_req_ack), 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish by %0t", $time);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;

      // single byte, last=1
      @(negedge clk);
      push_byte(0, 8'hA5, 1'b1);
      wait_quiet(200);
      elog.push_back({4'd0, 8'hA5});
      chk_log("single");

      // fairness: every client holds two single-byte packets; pointer sits at 1
      @(negedge clk);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < N; c++) push_byte(c, 8'(16*c + r), 1'b1);
      wait_quiet(500);
      for (int r = 0; r < 2; r++)
         for (int k = 1; k <= N; k++) elog.push_back({4'(k % N), 8'(16*(k % N) + r)});
      chk_log("fairness");

      // burst 11,22,33 from client 0 while client 2 arrives and waits
      @(negedge clk);
      push_byte(0, 8'h11, 1'b0);
      push_byte(0, 8'h22, 1'b0);
      push_byte(0, 8'h33, 1'b1);
      wait_start(0, 50);
      push_byte(2, 8'hC3, 1'b1);
      wait_quiet(300);
      elog.push_back({4'd0, 8'h11});
      elog.push_back({4'd0, 8'h22});
      elog.push_back({4'd0, 8'h33});
      elog.push_back({4'd2, 8'hC3});
      chk_log("burst");

      // burst cap: client 1 streams 20 bytes, others queue behind it
      @(negedge clk);
      for (int k = 0; k < 20; k++) push_byte(1, 8'(8'h80 + k), 1'b0);
      wait_start(1, 50);
      push_byte(0, 8'h40, 1'b1);
      push_byte(3, 8'h43, 1'b1);
      wait_quiet(2000);
      for (int k = 0; k < MB; k++) elog.push_back({4'd1, 8'(8'h80 + k)});
      elog.push_back({4'd3, 8'h43});
      elog.push_back({4'd0, 8'h40});
      for (int k = MB; k < 20; k++) elog.push_back({4'd1, 8'(8'h80 + k)});
      chk_log("burst_cap");

      // drop: client 3 withdraws its request while byte 2 is on the wire
      @(negedge clk);
      for (int k = 0; k < 4; k++) push_byte(3, 8'(8'hA0 + k), 1'b0);
      wait_start(3, 50);
      wait_start(3, 50);
      en[3] = 1'b0;
      wait_quiet(300);
      elog.push_back({4'd3, 8'hA0});
      elog.push_back({4'd3, 8'hA1});
      chk_log("drop");
      en[3] = 1'b1;
      wait_quiet(300);
      elog.push_back({4'd3, 8'hA2});
      elog.push_back({4'd3, 8'hA3});
      chk_log("drop_resume");

      // randomized traffic with random request withdrawal
      for (int p = 0; p < 40; p++) begin
         int c;
         int len;
         c = $urandom_range(0, N - 1);
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++)
            push_byte(c, 8'($urandom), (b == len - 1) && ($urandom_range(0, 3) != 0));
         repeat ($urandom_range(0, 15)) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) en[$urandom_range(0, N - 1)] ^= 1'b1;
         end
      end
      en = '1;
      wait_quiet(8000);
      log_rd = log_q.size();

      // reset in the middle of a frame, then a stray done tick, then normal traffic
      @(negedge clk);
      for (int k = 0; k < 6; k++) push_byte(2, 8'(8'hB0 + k), 1'b0);
      wait_start(2, 50);
      @(negedge clk);
      #1 reset = 1'b0;
      en = '0;
      #1 chk("async_reset", 32'({o_req_ack, o_grant, o_tx_start, o_tx_din, o_busy}), 32'd0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      log_rd = log_q.size();
      @(negedge clk);
      inj_req++;
      repeat (4) @(negedge clk);
      en = '1;
      wait_quiet(500);
      for (int k = 1; k < 6; k++) elog.push_back({4'd2, 8'(8'hB0 + k)});
      chk_log("after_reset");

      for (int c = 0; c < N; c++) chk("drained", 32'(exp_q[c].size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
